atm_host_responder: RTL and testbench

- Bank-side responder for the cajero automático front-end FSMs: the cashier FSMs ask, this block answers.
- Collects the 4-digit PIN, compares it against the stored PIN and counts failed attempts, locking the card after MAX_TRIES.
- Keeps the account balance and answers withdrawal requests with a valid/invalid verdict, debiting the balance on success.
- Sits between the keypad/card interface and the menu and withdrawal FSMs; drives their acceso, valido and invalido inputs.

---
 rtl/atm_host_responder.sv | 161 ++++++++++++++++
 tb/tb_atm_host_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_host_responder.sv
// Bank-side responder for the ATM front-end: PIN verification with lockout,
// balance keeping and withdrawal verdicts for the menu/withdrawal FSMs.
module atm_host_responder #(
  parameter logic [15:0]      PIN_CODE     = 16'h1926,
  parameter int unsigned      BAL_W        = 16,
  parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(1000),
  parameter int unsigned      MAX_TRIES    = 3,
  parameter logic [BAL_W-1:0] AMT_1        = BAL_W'(100),
  parameter logic [BAL_W-1:0] AMT_2        = BAL_W'(200),
  parameter logic [BAL_W-1:0] AMT_3        = BAL_W'(500),
  parameter logic [BAL_W-1:0] AMT_4        = BAL_W'(1000),
  parameter logic [BAL_W-1:0] AMT_5        = BAL_W'(2000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tarjeta,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             opcion_valid,
  input  logic [4:0]       opcion,
  output logic             acceso,
  output logic             pin_error,
  output logic             bloqueado,
  output logic             valido,
  output logic             invalido,
  output logic [BAL_W-1:0] monto,
  output logic [BAL_W-1:0] saldo
);

  localparam int unsigned TRY_W  = 3;
  localparam int unsigned DCNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN,
    S_CHECK,
    S_AUTH,
    S_WD
  } state_t;

  state_t              state;
  logic [15:0]         pin_reg;
  logic [DCNT_W-1:0]   digit_cnt;
  logic [TRY_W-1:0]    try_cnt;
  logic [TRY_W-1:0]    try_next;
  logic [BAL_W-1:0]    amount;
  logic [BAL_W-1:0]    sel_amount;
  logic                opcion_ok;

  // Decode the one-hot withdrawal option; anything else is rejected
  always_comb begin
    sel_amount = '0;
    opcion_ok  = 1'b0;
    case (opcion)
      5'b00001: begin sel_amount = AMT_1; opcion_ok = 1'b1; end
      5'b00010: begin sel_amount = AMT_2; opcion_ok = 1'b1; end
      5'b00100: begin sel_amount = AMT_3; opcion_ok = 1'b1; end
      5'b01000: begin sel_amount = AMT_4; opcion_ok = 1'b1; end
      5'b10000: begin sel_amount = AMT_5; opcion_ok = 1'b1; end
      default:  begin sel_amount = '0;    opcion_ok = 1'b0; end
    endcase
  end

  assign try_next = try_cnt + TRY_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      pin_reg   <= '0;
      digit_cnt <= '0;
      try_cnt   <= '0;
      amount    <= '0;
      saldo     <= INIT_BALANCE;
      acceso    <= 1'b0;
      pin_error <= 1'b0;
      bloqueado <= 1'b0;
      valido    <= 1'b0;
      invalido  <= 1'b0;
      monto     <= '0;
    end else begin
      pin_error <= 1'b0;
      valido    <= 1'b0;
      invalido  <= 1'b0;
      monto     <= '0;
      case (state)
        S_IDLE: begin
          if (tarjeta && !bloqueado) begin
            state     <= S_PIN;
            digit_cnt <= '0;
          end
        end
        S_PIN: begin
          if (!tarjeta) begin
            state     <= S_IDLE;
            digit_cnt <= '0;
          end else if (digit_valid) begin
            pin_reg   <= {pin_reg[11:0], digit};
            digit_cnt <= digit_cnt + DCNT_W'(1);
            if (digit_cnt == DCNT_W'(3)) state <= S_CHECK;
          end
        end
        // A card pulled during the compare abandons the attempt uncounted
        S_CHECK: begin
          if (!tarjeta) begin
            state     <= S_IDLE;
            digit_cnt <= '0;
          end else if (pin_reg == PIN_CODE) begin
            try_cnt <= '0;
            acceso  <= 1'b1;
            state   <= S_AUTH;
          end else begin
            pin_error <= 1'b1;
            try_cnt   <= try_next;
            digit_cnt <= '0;
            if (try_next == TRY_W'(MAX_TRIES)) begin
              bloqueado <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_PIN;
            end
          end
        end
        S_AUTH: begin
          if (!tarjeta) begin
            state     <= S_IDLE;
            acceso    <= 1'b0;
            digit_cnt <= '0;
          end else if (opcion_valid) begin
            if (opcion_ok) begin
              amount <= sel_amount;
              state  <= S_WD;
            end else begin
              invalido <= 1'b1;
            end
          end
        end
        // The verdict always completes, even if the card leaves this cycle
        S_WD: begin
          if (amount <= saldo) begin
            saldo  <= saldo - amount;
            valido <= 1'b1;
            monto  <= amount;
          end else begin
            invalido <= 1'b1;
          end
          if (!tarjeta) begin
            state     <= S_IDLE;
            acceso    <= 1'b0;
            digit_cnt <= '0;
          end else begin
            state <= S_AUTH;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_host_responder.sv
// Directed plus randomized bench for atm_host_responder, checked against a
// session-level bank model (balance, tries, lock, authorization).
module tb_atm_host_responder;

  localparam logic [15:0] PIN        = 16'h1926;
  localparam int unsigned MAXT       = 3;
  localparam int unsigned INIT_BAL   = 1000;
  localparam int unsigned AMTS [5]   = '{100, 200, 500, 1000, 2000};

  logic        clk = 1'b0;
  logic        reset;
  logic        tarjeta;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        opcion_valid;
  logic [4:0]  opcion;
  logic        acceso, pin_error, bloqueado, valido, invalido;
  logic [15:0] monto, saldo;

  int tests  = 0;
  int failed = 0;

  // Bank model state
  int unsigned m_bal;
  int unsigned m_tries;
  bit          m_locked;
  bit          m_auth;
  bit          m_card;

  atm_host_responder dut (
    .clk          (clk),
    .reset        (reset),
    .tarjeta      (tarjeta),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .opcion_valid (opcion_valid),
    .opcion       (opcion),
    .acceso       (acceso),
    .pin_error    (pin_error),
    .bloqueado    (bloqueado),
    .valido       (valido),
    .invalido     (invalido),
    .monto        (monto),
    .saldo        (saldo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned amt_of(input logic [4:0] o);
    if ($countones(o) != 1) return 0;
    for (int i = 0; i < 5; i++) if (o[i]) return AMTS[i];
    return 0;
  endfunction

  function automatic logic [15:0] rand_wrong_pin();
    logic [15:0] p;
    p = 16'($urandom);
    if (p == PIN) p = p ^ 16'h0001;
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b0; tarjeta = 1'b0; digit_valid = 1'b0; opcion_valid = 1'b0;
    digit = 4'd0; opcion = 5'd0;
    tick();
    reset = 1'b1;
    m_bal = INIT_BAL; m_tries = 0; m_locked = 1'b0; m_auth = 1'b0; m_card = 1'b0;
    check("rst_saldo", 32'(saldo), 32'(INIT_BAL));
    check("rst_acceso", 32'(acceso), 32'd0);
    check("rst_bloqueado", 32'(bloqueado), 32'd0);
    check("rst_pulses", {27'd0, pin_error, valido, invalido, 2'b00}, 32'd0);
    check("rst_monto", 32'(monto), 32'd0);
  endtask

  task automatic insert_card();
    tarjeta = 1'b1;
    tick();
    m_card = 1'b1;
  endtask

  task automatic remove_card();
    tarjeta = 1'b0;
    tick();
    m_card = 1'b0; m_auth = 1'b0;
    check("remove_acceso", 32'(acceso), 32'd0);
  endtask

  // Full PIN attempt; opcion strobes ride along and must be ignored
  task automatic enter_pin(input logic [15:0] p);
    bit active;
    bit exp_pe;
    active = m_card && !m_locked && !m_auth;
    for (int i = 0; i < 4; i++) begin
      digit_valid  = 1'b1;
      digit        = p[15-4*i -: 4];
      opcion_valid = 1'($urandom_range(0, 1));
      opcion       = 5'($urandom);
      tick();
      digit_valid  = 1'b0;
      opcion_valid = 1'b0;
    end
    check("pin_early_err", 32'(pin_error), 32'd0);
    check("pin_early_acc", 32'(acceso), 32'(m_auth));
    tick();
    exp_pe = 1'b0;
    if (active) begin
      if (p == PIN) begin
        m_tries = 0;
        m_auth  = 1'b1;
      end else begin
        exp_pe = 1'b1;
        m_tries++;
        if (m_tries >= MAXT) m_locked = 1'b1;
      end
    end
    check("pin_error", 32'(pin_error), 32'(exp_pe));
    check("pin_acceso", 32'(acceso), 32'(m_auth));
    check("pin_bloqueado", 32'(bloqueado), 32'(m_locked));
    tick();
    check("pin_error_1cyc", 32'(pin_error), 32'd0);
  endtask

  // Withdrawal request; optional card removal during the verdict cycle
  task automatic withdraw(input logic [4:0] o, input bit drop_card);
    int unsigned a;
    bit exp_v, exp_i;
    int nv, ni;
    a     = amt_of(o);
    exp_v = m_auth && (a != 0) && (a <= m_bal);
    exp_i = m_auth && !((a != 0) && (a <= m_bal));
    opcion_valid = 1'b1;
    opcion       = o;
    digit_valid  = m_auth ? 1'($urandom_range(0, 1)) : 1'b0;
    digit        = 4'($urandom);
    tick();
    opcion_valid = 1'b0;
    digit_valid  = 1'b0;
    nv = int'(valido);
    ni = int'(invalido);
    check("wd_no_early_valido", 32'(valido), 32'd0);
    if (drop_card) tarjeta = 1'b0;
    tick();
    nv += int'(valido);
    ni += int'(invalido);
    if (exp_v) m_bal -= a;
    if (drop_card) begin m_card = 1'b0; m_auth = 1'b0; end
    check("wd_valido", 32'(valido), 32'(exp_v));
    check("wd_monto", 32'(monto), exp_v ? 32'(a) : 32'd0);
    check("wd_saldo", 32'(saldo), 32'(m_bal));
    tick();
    nv += int'(valido);
    ni += int'(invalido);
    check("wd_valido_count", 32'(nv), 32'(exp_v));
    check("wd_invalido_count", 32'(ni), 32'(exp_i));
    check("wd_acceso", 32'(acceso), 32'(m_auth));
    check("wd_saldo_hold", 32'(saldo), 32'(m_bal));
  endtask

  initial begin
    logic [4:0] o;
    do_reset();

    // Correct PIN, then withdrawals down to the equality boundary
    insert_card();
    enter_pin(PIN);
    check("t1_saldo", 32'(saldo), 32'd1000);
    withdraw(5'b00100, 1'b0);
    withdraw(5'b01000, 1'b0);
    withdraw(5'b00100, 1'b0);
    check("t2_saldo_zero", 32'(saldo), 32'd0);

    // Malformed options and an over-balance request
    do_reset();
    insert_card();
    enter_pin(PIN);
    withdraw(5'b00011, 1'b0);
    withdraw(5'b00000, 1'b0);
    withdraw(5'b10000, 1'b0);
    withdraw(5'b01000, 1'b0);
    check("t5_saldo_zero", 32'(saldo), 32'd0);

    // Lockout after three wrong PINs; only reset clears it
    do_reset();
    insert_card();
    for (int k = 0; k < 3; k++) enter_pin(16'h0000);
    check("t3_locked", 32'(bloqueado), 32'd1);
    remove_card();
    insert_card();
    enter_pin(PIN);
    check("t3_locked_acceso", 32'(acceso), 32'd0);
    do_reset();

    // Successful PIN clears the try count
    insert_card();
    enter_pin(rand_wrong_pin());
    enter_pin(rand_wrong_pin());
    enter_pin(PIN);
    remove_card();
    insert_card();
    enter_pin(rand_wrong_pin());
    enter_pin(rand_wrong_pin());
    check("t4_not_locked", 32'(bloqueado), 32'd0);
    enter_pin(PIN);

    // Partial PIN discarded on card removal; removal during verdict cycle
    remove_card();
    insert_card();
    for (int i = 0; i < 2; i++) begin
      digit_valid = 1'b1;
      digit       = (i == 0) ? 4'd1 : 4'd9;
      tick();
      digit_valid = 1'b0;
    end
    remove_card();
    insert_card();
    enter_pin(PIN);
    withdraw(5'b00001, 1'b1);
    tick();
    check("t6_idle_acceso", 32'(acceso), 32'd0);
    check("t6_saldo", 32'(saldo), 32'(m_bal));

    // Randomized sessions
    do_reset();
    for (int s = 0; s < 4; s++) begin
      insert_card();
      withdraw(5'b00001, 1'b0);
      if ($urandom_range(0, 1) == 1) enter_pin(rand_wrong_pin());
      enter_pin(PIN);
      for (int r = 0; r < 8; r++) begin
        if ($urandom_range(0, 3) != 0) o = 5'(1 << $urandom_range(0, 4));
        else o = 5'($urandom);
        withdraw(o, 1'b0);
      end
      remove_card();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
